// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-ported data RAM between IF (read-only) and MEM (read/write).
// Define RAM_ARB_RR_EN for round-robin arbitration; the default is fixed MEM priority.
module ram_arbiter #(
  parameter int unsigned DW          = 16,
  parameter int unsigned AW          = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic          clk_50MHz,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  output logic          if_stall,
  input  logic          mem_req,
  input  logic          mem_op,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_ack,
  output logic          mem_stall,
  output logic          ram_en,
  output logic          ram_op,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          arb_busy
);

  // Bus encodings shared with the RAM and pipeline.
  localparam logic RamOpRd    = 1'b0;
  localparam logic RamOpWr    = 1'b1;
  localparam logic RamEnable  = 1'b1;
  localparam logic RamDisable = 1'b0;

  localparam int unsigned CntW =
    ($clog2(WAIT_CYCLES + 1) > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;
  typedef enum logic [1:0] {GntNone, GntIf, GntMem} grant_e;

  state_e            state_q, state_d;
  grant_e            grant_q, grant_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ram_op_q, ram_op_d;
  logic [AW-1:0]     ram_addr_q, ram_addr_d;
  logic [DW-1:0]     ram_wdata_q, ram_wdata_d;
  logic [DW-1:0]     if_rdata_q, if_rdata_d;
  logic [DW-1:0]     mem_rdata_q, mem_rdata_d;
  logic              start;
  logic              pick_mem;

  assign start = (state_q == StIdle) & (if_req | mem_req);

`ifdef RAM_ARB_RR_EN
  // 1 = MEM was granted last; resets to IF so the first tie goes to MEM.
  logic last_mem_q, last_mem_d;

  assign pick_mem   = mem_req & (~if_req | ~last_mem_q);
  assign last_mem_d = start ? pick_mem : last_mem_q;

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      last_mem_q <= 1'b0;
    end else begin
      last_mem_q <= last_mem_d;
    end
  end
`else
  assign pick_mem = mem_req;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    ram_op_d    = ram_op_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StBusy;
          cnt_d   = CntW'(WAIT_CYCLES);
          if (pick_mem) begin
            grant_d     = GntMem;
            ram_op_d    = mem_op;
            ram_addr_d  = mem_addr;
            ram_wdata_d = mem_wdata;
          end else begin
            grant_d     = GntIf;
            ram_op_d    = RamOpRd;
            ram_addr_d  = if_addr;
            ram_wdata_d = '0;
          end
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d  = StResp;
          // Drop back to read so a write strobe never outlives its BUSY window.
          ram_op_d = RamOpRd;
          if (grant_q == GntIf) begin
            if_rdata_d = ram_rdata;
          end else if (grant_q == GntMem && ram_op_q == RamOpRd) begin
            mem_rdata_d = ram_rdata;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= GntNone;
      cnt_q       <= '0;
      ram_op_q    <= RamOpRd;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      ram_op_q    <= ram_op_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_ack    = (state_q == StResp) && (grant_q == GntIf);
  assign mem_ack   = (state_q == StResp) && (grant_q == GntMem);
  assign if_stall  = if_req & ~if_ack;
  assign mem_stall = mem_req & ~mem_ack;
  assign ram_en    = (state_q == StBusy) ? RamEnable : RamDisable;
  assign ram_op    = ram_op_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign arb_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed table, multi-cycle corner sequences and a randomized
// run against a transaction-level model. Honours RAM_ARB_RR_EN when defined.
module tb_ram_arbiter;

  localparam int   W     = 1;
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, load;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        if_req, if_ack, if_stall, mem_req, mem_op, mem_ack, mem_stall;
  logic        ram_en, ram_op, arb_busy;
  logic [15:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;

  logic        if_req0, if_ack0, if_stall0, mem_ack0, mem_stall0, ram_en0, ram_op0, arb_busy0;
  logic [15:0] if_addr0, if_rdata0, mem_rdata0, ram_addr0, ram_wdata0, ram_rdata0;
  logic        zero1;
  logic [15:0] zero16;

  logic [15:0] ram  [256];
  logic [15:0] ram0 [256];
  logic [15:0] ref_mem [256];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ramf(input int i);
    return (i == 3) ? 16'hBEEF : 16'hA000 + 16'(i);
  endfunction

  assign ram_rdata  = ram[ram_addr[7:0]];
  assign ram_rdata0 = ram0[ram_addr0[7:0]];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) begin
        ram[i]  <= ramf(i);
        ram0[i] <= ramf(i);
      end
    end else begin
      if (ram_en && ram_op == OP_WR) ram[ram_addr[7:0]] <= ram_wdata;
      if (ram_en0 && ram_op0 == OP_WR) ram0[ram_addr0[7:0]] <= ram_wdata0;
    end
  end

  ram_arbiter #(.DW(16), .AW(16), .WAIT_CYCLES(W)) dut (
    .clk_50MHz(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .if_stall(if_stall), .mem_req(mem_req), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_stall(mem_stall),
    .ram_en(ram_en), .ram_op(ram_op), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .arb_busy(arb_busy)
  );

  ram_arbiter #(.DW(16), .AW(16), .WAIT_CYCLES(0)) dut0 (
    .clk_50MHz(clk), .rst(rst),
    .if_req(if_req0), .if_addr(if_addr0), .if_rdata(if_rdata0), .if_ack(if_ack0),
    .if_stall(if_stall0), .mem_req(zero1), .mem_op(zero1), .mem_addr(zero16),
    .mem_wdata(zero16), .mem_rdata(mem_rdata0), .mem_ack(mem_ack0), .mem_stall(mem_stall0),
    .ram_en(ram_en0), .ram_op(ram_op0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
    .ram_rdata(ram_rdata0), .arb_busy(arb_busy0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Single isolated transaction from an idle arbiter.
  task automatic do_txn(input logic is_mem, input logic op, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [15:0] exp_rd, input string nm);
    int start, got, en_cnt, op_err, stall_err;
    logic [15:0] rd;
    got = -1; en_cnt = 0; op_err = 0; stall_err = 0; rd = '0;
    @(posedge clk); #1;
    if (is_mem) begin
      mem_req = 1'b1; mem_op = op; mem_addr = addr; mem_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    start = cyc;
    for (int i = 0; i < 12 && got < 0; i++) begin
      @(negedge clk);
      if (ram_en) en_cnt++;
      if (ram_op !== (ram_en ? (is_mem & op) : OP_RD)) op_err++;
      if (is_mem ? mem_ack : if_ack) begin
        got = cyc;
        rd  = is_mem ? mem_rdata : if_rdata;
        if ((is_mem ? mem_stall : if_stall) !== 1'b0) stall_err++;
      end else if ((is_mem ? mem_stall : if_stall) !== 1'b1) begin
        stall_err++;
      end
    end
    chk({nm, " latency"}, got - start, W + 2);
    chk({nm, " ram_en cycles"}, en_cnt, W + 1);
    chk({nm, " ram_op"}, op_err, 0);
    chk({nm, " stall"}, stall_err, 0);
    chk({nm, " rdata"}, rd, exp_rd);
    @(posedge clk); #1;
    if (is_mem) mem_req = 1'b0; else if_req = 1'b0;
  endtask

  typedef struct {
    logic        is_mem;
    logic        op;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] exp_rd;
  } vec_t;

  initial begin
    vec_t        tbl [6];
    int          s, ma, ia, n;
    int          own [4];
    int          at [4];
    logic [15:0] dat [4];
    logic        got;
    // Random-phase model state
    bit          act, wm, t_wr, p_if, p_mem, e_if, e_mem, e_en, e_busy, last_mem;
    int          g_c, ack_at;
    logic [15:0] t_addr, t_wd, t_data, x_if, x_mem;

    tbl[0] = '{1'b0, OP_RD, 16'h0003, 16'h0000, 16'hBEEF};
    tbl[1] = '{1'b1, OP_WR, 16'h0005, 16'h1234, 16'h0000};
    tbl[2] = '{1'b1, OP_RD, 16'h0005, 16'h0000, 16'h1234};
    tbl[3] = '{1'b1, OP_WR, 16'h00FF, 16'hFFFF, 16'h1234};
    tbl[4] = '{1'b1, OP_RD, 16'h0003, 16'h0000, 16'hBEEF};
    tbl[5] = '{1'b0, OP_RD, 16'h00FF, 16'h0000, 16'hFFFF};

    rst = 1'b1; load = 1'b1; zero1 = 1'b0; zero16 = '0;
    if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_op = OP_RD; mem_addr = '0;
    mem_wdata = '0; if_req0 = 1'b0; if_addr0 = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; load = 1'b0;

    @(negedge clk);
    chk("reset ram_en", ram_en, 0);
    chk("reset ram_op", ram_op, OP_RD);
    chk("reset ram_addr", ram_addr, 0);
    chk("reset ram_wdata", ram_wdata, 0);
    chk("reset if_ack", if_ack, 0);
    chk("reset mem_ack", mem_ack, 0);
    chk("reset if_rdata", if_rdata, 0);
    chk("reset mem_rdata", mem_rdata, 0);
    chk("reset arb_busy", arb_busy, 0);

    for (int i = 0; i < 6; i++)
      do_txn(tbl[i].is_mem, tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].exp_rd,
             $sformatf("vec%0d", i));

    // Simultaneous request: MEM first, IF re-arbitrated in the following IDLE.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0003; mem_req = 1'b1; mem_op = OP_RD; mem_addr = 16'h0005;
    s = cyc; ma = -1; ia = -1;
    for (int i = 0; i < 20 && ia < 0; i++) begin
      @(negedge clk);
      if (mem_ack && ma < 0) begin
        ma = cyc;
        chk("tie mem_rdata", mem_rdata, 16'h1234);
      end
      if (if_ack) begin
        ia = cyc;
        chk("tie if_rdata", if_rdata, 16'hBEEF);
      end
      if (ia < 0) chk("tie if_stall", if_stall, 1);
      @(posedge clk); #1;
      if (ma >= 0) mem_req = 1'b0;
      if (ia >= 0) if_req = 1'b0;
    end
    chk("tie mem ack time", ma - s, W + 2);
    chk("tie if ack time", ia - s, 2 * (W + 3) - 1);

    // Both held for four grants: fixed priority starves IF, round-robin alternates.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0003; mem_req = 1'b1; mem_op = OP_RD; mem_addr = 16'h0005;
    n = 0;
    for (int j = 0; j < 4; j++) begin own[j] = -1; at[j] = 0; end
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (mem_ack || if_ack) begin
        own[n] = mem_ack ? 1 : 0; at[n] = cyc; n++;
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0; mem_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("starve owner%0d", j), own[j], RR ? ((j % 2 == 0) ? 1 : 0) : 1);
      if (j > 0) chk($sformatf("starve gap%0d", j), at[j] - at[j-1], W + 3);
    end

    // Reset pulsed during BUSY of a MEM read.
    @(posedge clk); #1;
    mem_req = 1'b1; mem_op = OP_RD; mem_addr = 16'h0003;
    @(posedge clk); #1;
    chk("pre-rst ram_en", ram_en, 1);
    rst = 1'b1; mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst ram_en", ram_en, 0);
    chk("rst if_ack", if_ack, 0);
    chk("rst mem_ack", mem_ack, 0);
    chk("rst if_rdata", if_rdata, 0);
    chk("rst mem_rdata", mem_rdata, 0);
    chk("rst arb_busy", arb_busy, 0);
    chk("rst ram_addr", ram_addr, 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_ack) n++;
    end
    chk("rst no late ack", n, 0);
    do_txn(1'b0, OP_RD, 16'h0003, 16'h0000, 16'hBEEF, "post-rst if");

    // WAIT_CYCLES=0 instance: IF held for four transactions.
    @(posedge clk); #1;
    if_req0 = 1'b1; if_addr0 = 16'h0000;
    s = cyc; n = 0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      @(negedge clk);
      got = if_ack0;
      if (got) begin at[n] = cyc; dat[n] = if_rdata0; n++; end
      @(posedge clk); #1;
      if (got) if_addr0 = 16'(n);
      if (n == 4) if_req0 = 1'b0;
    end
    chk("w0 ack count", n, 4);
    chk("w0 first ack", at[0] - s, 2);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("w0 rdata%0d", j), dat[j], ramf(j));
      if (j > 0) chk($sformatf("w0 gap%0d", j), at[j] - at[j-1], 3);
    end

    // Randomized traffic against a transaction-level model.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];
    act = 1'b0; p_if = 1'b0; p_mem = 1'b0; last_mem = 1'b0; x_if = '0; x_mem = '0;
    g_c = 0; ack_at = 0; t_wr = 1'b0; wm = 1'b0; t_addr = '0; t_wd = '0; t_data = '0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (if_req && p_if) if_req = 1'b0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = 16'($urandom_range(0, 15));
      end
      if (mem_req && p_mem) mem_req = 1'b0;
      else if (!mem_req && $urandom_range(0, 2) == 0) begin
        mem_req = 1'b1; mem_op = 1'($urandom_range(0, 1));
        mem_addr = 16'($urandom_range(0, 15)); mem_wdata = 16'($urandom);
      end
      if (act && cyc > ack_at) act = 1'b0;
      if (!act && (if_req || mem_req)) begin
        wm = mem_req && (!if_req || !RR || !last_mem);
        last_mem = wm;
        act = 1'b1; g_c = cyc; ack_at = cyc + W + 2;
        t_wr   = wm && (mem_op == OP_WR);
        t_addr = wm ? mem_addr : if_addr;
        t_wd   = wm ? mem_wdata : 16'h0000;
        if (t_wr) ref_mem[t_addr[7:0]] = t_wd;
        else t_data = ref_mem[t_addr[7:0]];
      end
      e_if   = act && !wm && cyc == ack_at;
      e_mem  = act && wm && cyc == ack_at;
      e_en   = act && cyc > g_c && cyc <= g_c + W + 1;
      e_busy = act && cyc > g_c;
      if (e_if) x_if = t_data;
      if (e_mem && !t_wr) x_mem = t_data;
      @(negedge clk);
      chk("rnd if_ack", if_ack, e_if);
      chk("rnd mem_ack", mem_ack, e_mem);
      chk("rnd if_rdata", if_rdata, x_if);
      chk("rnd mem_rdata", mem_rdata, x_mem);
      chk("rnd if_stall", if_stall, if_req & ~e_if);
      chk("rnd mem_stall", mem_stall, mem_req & ~e_mem);
      chk("rnd ram_en", ram_en, e_en);
      chk("rnd arb_busy", arb_busy, e_busy);
      chk("rnd ram_op", ram_op, e_en ? t_wr : OP_RD);
      if (e_en) begin
        chk("rnd ram_addr", ram_addr, t_addr);
        chk("rnd ram_wdata", ram_wdata, t_wd);
      end
      p_if = e_if; p_mem = e_mem;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
